// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer
// Four-state instruction sequencer for the 8-bit CPU register file port side.
// It accepts one 32-bit instruction in IDLE and latches the fields it needs.
// In DECODE it registers the read/write addresses and ALU controls.
// In EXEC those controls are held while the register file and ALU settle.
// In WB it issues a single write strobe, or flags an unknown opcode as illegal.
// Every output is registered except READY, which is decoded from the state.

module reg_write_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    output logic        READY,
    output logic [7:0]  PC,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic        WRITEENABLE,
    output logic [2:0]  ALUOP,
    output logic [7:0]  IMMEDIATE,
    output logic        IMMSEL,
    output logic        NEGSEL,
    output logic        ILLEGAL,
    output logic [15:0] RETIRED
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [2:0] ALU_FORWARD = 3'b000;
    localparam logic [2:0] ALU_ADD     = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_OR      = 3'b011;

    // Decoded control bundle: {legal, aluop[2:0], immsel, negsel}
    typedef struct packed {
        logic       legal;
        logic [2:0] aluop;
        logic       immsel;
        logic       negsel;
    } ctrl_t;

    state_t      r_state;
    logic [7:0]  r_opcode;
    logic [2:0]  r_dest;
    logic [2:0]  r_src1;
    logic [7:0]  r_src2;
    logic        r_legal;
    logic [7:0]  r_pc;
    logic [2:0]  r_readreg1;
    logic [2:0]  r_readreg2;
    logic [2:0]  r_writereg;
    logic        r_writeenable;
    logic [2:0]  r_aluop;
    logic [7:0]  r_immediate;
    logic        r_immsel;
    logic        r_negsel;
    logic        r_illegal;
    logic [15:0] r_retired;

    ctrl_t       w_ctrl;
    logic        w_unused_fields;

    // Opcode decode. Unknown opcodes get loadi-style controls but are not legal,
    // so no write-back happens for them.
    function automatic ctrl_t f_decode(input logic [7:0] opcode);
        ctrl_t c;
        c = '{legal: 1'b0, aluop: ALU_FORWARD, immsel: 1'b1, negsel: 1'b0};
        case (opcode)
            8'h00: c = '{legal: 1'b1, aluop: ALU_FORWARD, immsel: 1'b1, negsel: 1'b0};
            8'h01: c = '{legal: 1'b1, aluop: ALU_FORWARD, immsel: 1'b0, negsel: 1'b0};
            8'h02: c = '{legal: 1'b1, aluop: ALU_ADD,     immsel: 1'b0, negsel: 1'b0};
            8'h03: c = '{legal: 1'b1, aluop: ALU_ADD,     immsel: 1'b0, negsel: 1'b1};
            8'h04: c = '{legal: 1'b1, aluop: ALU_AND,     immsel: 1'b0, negsel: 1'b0};
            8'h05: c = '{legal: 1'b1, aluop: ALU_OR,      immsel: 1'b0, negsel: 1'b0};
            default: c = '{legal: 1'b0, aluop: ALU_FORWARD, immsel: 1'b1, negsel: 1'b0};
        endcase
        return c;
    endfunction

    // Decode the latched opcode so the input bus may change after acceptance
    always_comb begin
        w_ctrl = f_decode(r_opcode);
    end

    // Upper bits of the register fields are architecturally ignored
    assign w_unused_fields = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

    // Sequencer state, instruction latch and all registered outputs.
    // The reset is asynchronous, so an in-flight write strobe drops immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= S_IDLE;
            r_opcode      <= 8'h00;
            r_dest        <= 3'd0;
            r_src1        <= 3'd0;
            r_src2        <= 8'h00;
            r_legal       <= 1'b0;
            r_pc          <= 8'h00;
            r_readreg1    <= 3'd0;
            r_readreg2    <= 3'd0;
            r_writereg    <= 3'd0;
            r_writeenable <= 1'b0;
            r_aluop       <= ALU_FORWARD;
            r_immediate   <= 8'h00;
            r_immsel      <= 1'b0;
            r_negsel      <= 1'b0;
            r_illegal     <= 1'b0;
            r_retired     <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_writeenable <= 1'b0;
                    r_illegal     <= 1'b0;
                    if (INSTR_VALID) begin
                        r_opcode <= INSTRUCTION[31:24];
                        r_dest   <= INSTRUCTION[18:16];
                        r_src1   <= INSTRUCTION[10:8];
                        r_src2   <= INSTRUCTION[7:0];
                        // 8-bit PC wraps naturally from 0xFC to 0x00
                        r_pc     <= r_pc + 8'd4;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_readreg1  <= r_src1;
                    r_readreg2  <= r_src2[2:0];
                    r_writereg  <= r_dest;
                    r_immediate <= r_src2;
                    r_aluop     <= w_ctrl.aluop;
                    r_immsel    <= w_ctrl.immsel;
                    r_negsel    <= w_ctrl.negsel;
                    r_legal     <= w_ctrl.legal;
                    r_state     <= S_EXEC;
                end
                S_EXEC: begin
                    // Controls stay put; the write strobe or illegal flag
                    // becomes visible for exactly the WB cycle.
                    if (r_legal) begin
                        r_writeenable <= 1'b1;
                        r_retired     <= r_retired + 16'd1;
                    end else begin
                        r_illegal     <= 1'b1;
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_writeenable <= 1'b0;
                    r_illegal     <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_writeenable <= 1'b0;
                    r_illegal     <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign READY       = (r_state == S_IDLE);
    assign PC          = r_pc;
    assign READREG1    = r_readreg1;
    assign READREG2    = r_readreg2;
    assign WRITEREG    = r_writereg;
    assign WRITEENABLE = r_writeenable;
    assign ALUOP       = r_aluop;
    assign IMMEDIATE   = r_immediate;
    assign IMMSEL      = r_immsel;
    assign NEGSEL      = r_negsel;
    assign ILLEGAL     = r_illegal;
    assign RETIRED     = r_retired;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Testbench for reg_write_sequencer: directed instructions with hand-computed
// controls; a scoreboard queue is filled at issue and drained by a monitor
// whenever the DUT shows a write strobe or illegal pulse.

module tb_reg_write_sequencer;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        READY;
    logic [7:0]  PC;
    logic [2:0]  READREG1;
    logic [2:0]  READREG2;
    logic [2:0]  WRITEREG;
    logic        WRITEENABLE;
    logic [2:0]  ALUOP;
    logic [7:0]  IMMEDIATE;
    logic        IMMSEL;
    logic        NEGSEL;
    logic        ILLEGAL;
    logic [15:0] RETIRED;

    reg_write_sequencer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .INSTR_VALID (INSTR_VALID),
        .READY       (READY),
        .PC          (PC),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .WRITEREG    (WRITEREG),
        .WRITEENABLE (WRITEENABLE),
        .ALUOP       (ALUOP),
        .IMMEDIATE   (IMMEDIATE),
        .IMMSEL      (IMMSEL),
        .NEGSEL      (NEGSEL),
        .ILLEGAL     (ILLEGAL),
        .RETIRED     (RETIRED)
    );

    typedef struct {
        logic [2:0]  wr;
        logic [2:0]  rr1;
        logic [2:0]  rr2;
        logic [2:0]  alu;
        logic [7:0]  imm;
        logic        immsel;
        logic        negsel;
        logic        legal;
        logic [15:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_tests;
    int          n_fail;
    logic [7:0]  exp_pc;
    logic [15:0] exp_ret;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!READY && k < 16) begin
            tick();
            k++;
        end
        if (!READY) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got READY=0 expected READY=1 within 16 cycles");
        end
    endtask

    task automatic push_exp(input logic [31:0] ins, input logic [2:0] alu,
                            input logic immsel, input logic negsel, input logic legal);
        exp_t e;
        if (legal) exp_ret = exp_ret + 16'd1;
        e.wr     = ins[18:16];
        e.rr1    = ins[10:8];
        e.rr2    = ins[2:0];
        e.imm    = ins[7:0];
        e.alu    = alu;
        e.immsel = immsel;
        e.negsel = negsel;
        e.legal  = legal;
        e.ret    = exp_ret;
        sb_q.push_back(e);
    endtask

    // Present one instruction in IDLE, check the PC after the accept edge,
    // then scramble the bus so only the latched copy can be used.
    task automatic issue(input logic [31:0] ins, input logic [2:0] alu, input logic immsel,
                         input logic negsel, input logic legal, input logic do_push);
        wait_ready();
        INSTRUCTION = ins;
        INSTR_VALID = 1'b1;
        if (do_push) push_exp(ins, alu, immsel, negsel, legal);
        tick();
        exp_pc = exp_pc + 8'd4;
        chk("pc_after_accept", {24'd0, PC}, {24'd0, exp_pc});
        INSTR_VALID = 1'b0;
        INSTRUCTION = ~ins;
    endtask

    // Scoreboard monitor: every strobe/illegal cycle must match the oldest entry
    always @(negedge CLK) begin
        if (RESET === 1'b1 && (WRITEENABLE === 1'b1 || ILLEGAL === 1'b1)) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got WE=%0b ILLEGAL=%0b expected no strobe", WRITEENABLE, ILLEGAL);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_writeenable", {31'd0, WRITEENABLE}, {31'd0, mon_e.legal});
                chk("wb_illegal",     {31'd0, ILLEGAL},     {31'd0, ~mon_e.legal});
                chk("wb_writereg",    {29'd0, WRITEREG},    {29'd0, mon_e.wr});
                chk("wb_readreg1",    {29'd0, READREG1},    {29'd0, mon_e.rr1});
                chk("wb_readreg2",    {29'd0, READREG2},    {29'd0, mon_e.rr2});
                chk("wb_aluop",       {29'd0, ALUOP},       {29'd0, mon_e.alu});
                chk("wb_immediate",   {24'd0, IMMEDIATE},   {24'd0, mon_e.imm});
                chk("wb_immsel",      {31'd0, IMMSEL},      {31'd0, mon_e.immsel});
                chk("wb_negsel",      {31'd0, NEGSEL},      {31'd0, mon_e.negsel});
                chk("wb_retired",     {16'd0, RETIRED},     {16'd0, mon_e.ret});
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_tests     = 0;
        n_fail      = 0;
        exp_pc      = 8'h00;
        exp_ret     = 16'h0000;
        RESET       = 1'b0;
        INSTR_VALID = 1'b0;
        INSTRUCTION = 32'h0;

        // Reset values
        tick();
        chk("rst_ready",    {31'd0, READY},       32'd1);
        chk("rst_pc",       {24'd0, PC},          32'd0);
        chk("rst_we",       {31'd0, WRITEENABLE}, 32'd0);
        chk("rst_illegal",  {31'd0, ILLEGAL},     32'd0);
        chk("rst_retired",  {16'd0, RETIRED},     32'd0);
        chk("rst_aluop",    {29'd0, ALUOP},       32'd0);
        chk("rst_writereg", {29'd0, WRITEREG},    32'd0);
        chk("rst_imm",      {24'd0, IMMEDIATE},   32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // loadi r4, 0x2A with cycle-by-cycle timing
        issue(32'h00_04_00_2A, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t1_ready_busy", {31'd0, READY},       32'd0);
        chk("t1_we_decode",  {31'd0, WRITEENABLE}, 32'd0);
        tick();
        chk("t1_writereg",   {29'd0, WRITEREG},    32'd4);
        chk("t1_immsel",     {31'd0, IMMSEL},      32'd1);
        chk("t1_aluop",      {29'd0, ALUOP},       32'd0);
        chk("t1_immediate",  {24'd0, IMMEDIATE},   32'h2A);
        chk("t1_we_exec",    {31'd0, WRITEENABLE}, 32'd0);
        tick();
        chk("t1_we_wb",      {31'd0, WRITEENABLE}, 32'd1);
        chk("t1_retired",    {16'd0, RETIRED},     32'd1);
        tick();
        chk("t1_we_idle",    {31'd0, WRITEENABLE}, 32'd0);
        chk("t1_ready_idle", {31'd0, READY},       32'd1);
        chk("t1_hold_wr",    {29'd0, WRITEREG},    32'd4);

        // sub r2 = r1 - r3
        issue(32'h03_02_01_03, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1);
        // Unknown opcode 0x07
        issue(32'h07_05_06_01, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        // mov and and
        issue(32'h01_06_02_00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(32'h04_07_05_06, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_ready();
        chk("illegal_retired", {16'd0, RETIRED}, {16'd0, exp_ret});

        // INSTR_VALID held high: loadi, add, or accepted every 4 cycles
        INSTRUCTION = 32'h00_01_00_11;
        INSTR_VALID = 1'b1;
        push_exp(32'h00_01_00_11, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        exp_pc = exp_pc + 8'd4;
        chk("b2b_pc0", {24'd0, PC}, {24'd0, exp_pc});
        INSTRUCTION = 32'h02_03_01_02;
        push_exp(32'h02_03_01_02, 3'b001, 1'b0, 1'b0, 1'b1);
        tick(); tick(); tick();
        chk("b2b_ready_gap", {31'd0, READY}, 32'd1);
        chk("b2b_pc_hold",   {24'd0, PC},    {24'd0, exp_pc});
        tick();
        exp_pc = exp_pc + 8'd4;
        chk("b2b_pc1", {24'd0, PC}, {24'd0, exp_pc});
        INSTRUCTION = 32'h05_05_03_04;
        push_exp(32'h05_05_03_04, 3'b011, 1'b0, 1'b0, 1'b1);
        tick(); tick(); tick(); tick();
        exp_pc = exp_pc + 8'd4;
        chk("b2b_pc2", {24'd0, PC}, {24'd0, exp_pc});
        INSTR_VALID = 1'b0;
        INSTRUCTION = 32'hFF_FF_FF_FF;
        wait_ready();
        chk("b2b_retired", {16'd0, RETIRED}, {16'd0, exp_ret});

        // 64 loadi instructions carry the PC all the way round
        for (int i = 0; i < 64; i++) begin
            logic [31:0] ins;
            ins = {8'h00, 5'd0, i[2:0], 8'h00, i[7:0]};
            issue(ins, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
            if (exp_pc == 8'h00) chk("pc_wrap", {24'd0, PC}, 32'd0);
        end

        // Asynchronous reset in the middle of WB
        wait_ready();
        issue(32'h02_05_04_03, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk("arst_we_before", {31'd0, WRITEENABLE}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_we",       {31'd0, WRITEENABLE}, 32'd0);
        chk("arst_ready",    {31'd0, READY},       32'd1);
        chk("arst_pc",       {24'd0, PC},          32'd0);
        chk("arst_retired",  {16'd0, RETIRED},     32'd0);
        chk("arst_writereg", {29'd0, WRITEREG},    32'd0);
        chk("arst_readreg1", {29'd0, READREG1},    32'd0);
        chk("arst_readreg2", {29'd0, READREG2},    32'd0);
        chk("arst_aluop",    {29'd0, ALUOP},       32'd0);
        chk("arst_imm",      {24'd0, IMMEDIATE},   32'd0);
        chk("arst_immsel",   {31'd0, IMMSEL},      32'd0);
        chk("arst_negsel",   {31'd0, NEGSEL},      32'd0);
        chk("arst_illegal",  {31'd0, ILLEGAL},     32'd0);
        exp_pc  = 8'h00;
        exp_ret = 16'h0000;
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // Normal operation resumes after reset
        issue(32'h02_06_07_01, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_ready();
        chk("post_rst_retired", {16'd0, RETIRED}, 32'd1);

        // Drain the scoreboard
        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            tick();
            k++;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
